// File: rtl/timer_share_arbiter.sv
// Round-robin owner of one shared delay timer: grants a requester, counts (delay+1)*TICKS cycles, then holds done until acked.
// Optional build macro TIMER_SHARE_ABORT_EN: the owner dropping its req during COUNT abandons the job.
module timer_share_arbiter #(
  parameter int N     = 4,
  parameter int TICKS = 1000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_i,
  input  logic [4*N-1:0] delay_i,
  input  logic [N-1:0]   ack_i,
  output logic [N-1:0]   grant_o,
  output logic           busy_o,
  output logic [3:0]     count_o,
  output logic [N-1:0]   done_o
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TICKS);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   own_q, own_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      count_q, count_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            abort;

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = IW'((int'(last_q) + k) % N);
      if (!win_vld && req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

`ifdef TIMER_SHARE_ABORT_EN
  assign abort = ~req_i[own_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    tick_d  = tick_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_COUNT;
          own_d   = win_idx;
          count_d = delay_i[{win_idx, 2'b00} +: 4];
          tick_d  = TW'(TICKS - 1);
          grant_d = N'(1) << win_idx;
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d = S_IDLE;
          last_d  = own_q;
          count_d = 4'd0;
          tick_d  = '0;
          grant_d = '0;
        end else if (tick_q != '0) begin
          tick_d = tick_q - TW'(1);
        end else if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
          tick_d  = TW'(TICKS - 1);
        end else begin
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        if (ack_i[own_q]) begin
          state_d = S_IDLE;
          last_d  = own_q;
          grant_d = '0;
          done_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N - 1);
      own_q   <= '0;
      tick_q  <= '0;
      count_q <= 4'd0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule
